aes128_rk_sequencer: RTL and testbench

//  Registered round-key bank placed directly downstream of the combinational AES-128 key scheduler.

---
 rtl/aes128_rk_sequencer_if.sv | 28 ++
 rtl/aes128_rk_sequencer.sv | 122 ++++++++++++
 tb/tb_aes128_rk_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_rk_sequencer_if.sv
// Round-key bank bus: scheduler capture inputs plus the reverse-order
// key stream towards the inverse-cipher round engine.
// master = key sequencer, slave = scheduler/engine side (or a testbench).
interface aes128_rk_sequencer_if #(
   parameter int NR    = 10,
   parameter int KEY_W = 128
);
   logic                    key_load;
   logic [(NR+1)*KEY_W-1:0] in_keys;
   logic                    start;
   logic [KEY_W-1:0]        rk_data;
   logic [3:0]              rk_round;
   logic                    rk_valid;
   logic                    rk_ready;
   logic                    rk_last;
   logic                    loaded;
   logic                    done;

   modport master (
      input  key_load, in_keys, start, rk_ready,
      output rk_data, rk_round, rk_valid, rk_last, loaded, done
   );

   modport slave (
      output key_load, in_keys, start, rk_ready,
      input  rk_data, rk_round, rk_valid, rk_last, loaded, done
   );
endinterface

// File: rtl/aes128_rk_sequencer.sv
// AES-128 round-key sequencer: captures all NR+1 expanded round keys in
// one cycle and streams them key[NR] down to key[0], one per handshake.
// Optional feature macro: AES128_KEY_ZEROIZE_EN adds a zeroize input that
// clears the bank and returns the block to IDLE.
module aes128_rk_sequencer #(
   parameter int NR    = 10,
   parameter int KEY_W = 128
) (
   input  logic clk,
   input  logic rst,
`ifdef AES128_KEY_ZEROIZE_EN
   input  logic zeroize,
`endif
   aes128_rk_sequencer_if.master bus
);

   localparam int         BANK_W   = (NR + 1) * KEY_W;
   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef enum logic [1:0] {IDLE = 2'd0, LOADED = 2'd1, SERVE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [BANK_W-1:0]  bank_q;
   logic [KEY_W-1:0]   data_q, data_d;
   logic [3:0]         rnd_q, rnd_d;
   logic [3:0]         rnd_dec;
   logic               done_q, done_d;
   logic               bank_we, bank_clr;
   logic               xfer;
   logic               zero_req;

`ifdef AES128_KEY_ZEROIZE_EN
   assign zero_req = zeroize;
`else
   assign zero_req = 1'b0;
`endif

   assign xfer    = (state_q == SERVE) && bus.rk_ready;
   assign rnd_dec = rnd_q - 4'd1;

   // Next-state and next-output selection; zeroize beats key_load beats start.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      rnd_d    = rnd_q;
      done_d   = 1'b0;
      bank_we  = 1'b0;
      bank_clr = 1'b0;
      if (zero_req) begin
         state_d  = IDLE;
         bank_clr = 1'b1;
         data_d   = '0;
         rnd_d    = '0;
      end else if (bus.key_load) begin
         bank_we = 1'b1;
         if (bus.start) begin
            // new schedule is not in the bank yet, so take key[NR] from the input
            state_d = SERVE;
            rnd_d   = LAST_RND;
            data_d  = bus.in_keys[KEY_W*NR +: KEY_W];
         end else begin
            state_d = LOADED;
         end
      end else begin
         unique case (state_q)
            LOADED: begin
               if (bus.start) begin
                  state_d = SERVE;
                  rnd_d   = LAST_RND;
                  data_d  = bank_q[KEY_W*NR +: KEY_W];
               end
            end
            SERVE: begin
               if (xfer) begin
                  if (rnd_q == 4'd0) begin
                     state_d = LOADED;
                     done_d  = 1'b1;
                  end else begin
                     rnd_d  = rnd_dec;
                     data_d = bank_q[KEY_W*32'(rnd_dec) +: KEY_W];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         rnd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   // Round-key bank capture and clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q <= '0;
      end else if (bank_clr) begin
         bank_q <= '0;
      end else if (bank_we) begin
         bank_q <= bus.in_keys;
      end
   end

   assign bus.rk_data  = data_q;
   assign bus.rk_round = rnd_q;
   assign bus.rk_valid = (state_q == SERVE);
   assign bus.rk_last  = (state_q == SERVE) && (rnd_q == 4'd0);
   assign bus.loaded   = (state_q != IDLE);
   assign bus.done     = done_q;

endmodule

// File: tb/tb_aes128_rk_sequencer.sv
// Testbench for aes128_rk_sequencer: directed FIPS-197 round-key schedules,
// scoreboard queue filled by the driver, drained by a negedge monitor.
// Define AES128_KEY_ZEROIZE_EN to also exercise zeroize.
module tb_aes128_rk_sequencer;

   localparam int KW = 128;
   localparam int BW = 11 * KW;

   // FIPS-197 C.1 key 000102..0f, round keys 10 down to 0
   localparam logic [BW-1:0] KEYS_A = {
      128'h13111d7fe3944a17f307a78b4d2b30c5,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h47438735a41c65b9e016baf4aef7ad1f,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hd6aa74fdd2af72fadaa678f1d6ad76fe,
      128'h000102030405060708090a0b0c0d0e0f};

   // FIPS-197 A.1 key 2b7e1516..., round keys 10 down to 0
   localparam logic [BW-1:0] KEYS_B = {
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
      128'hac7766f319fadc2128d12941575c006e,
      128'head27321b58dbad2312bf5607f8d292f,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'h2b7e151628aed2a6abf7158809cf4f3c};

   typedef struct packed {
      logic [3:0]    rnd;
      logic [KW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
`ifdef AES128_KEY_ZEROIZE_EN
   logic zeroize;
`endif

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   aes128_rk_sequencer_if #(.NR(10), .KEY_W(KW)) bus ();

   aes128_rk_sequencer #(.NR(10), .KEY_W(KW)) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef AES128_KEY_ZEROIZE_EN
      .zeroize (zeroize),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_pass(input logic [BW-1:0] k);
      exp_t e;
      for (int r = 10; r >= 0; r--) begin
         e.rnd  = 4'(r);
         e.data = k[KW*r +: KW];
         q.push_back(e);
      end
   endtask

   task automatic load(input logic [BW-1:0] k);
      bus.in_keys  = k;
      bus.key_load = 1'b1;
      tick();
      bus.key_load = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_drain(input string name, input bit rand_ready);
      int cyc = 0;
      while (q.size() != 0 && cyc < 400) begin
         if (rand_ready) bus.rk_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      chk({name, "_drain_left"}, KW'(q.size()), '0);
      q.delete();
      bus.rk_ready = 1'b1;
      ticks(3);
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_valid"}, KW'(bus.rk_valid), '0);
      chk({name, "_data"},  bus.rk_data,        '0);
      chk({name, "_round"}, KW'(bus.rk_round), '0);
      chk({name, "_last"},  KW'(bus.rk_last),  '0);
      chk({name, "_loaded"}, KW'(bus.loaded),  '0);
      chk({name, "_done"},  KW'(bus.done),     '0);
   endtask

   // Monitor: pops the scoreboard on each transfer, checks stall stability and done timing.
   bit            st_valid = 1'b0;
   bit            exp_done = 1'b0;
   logic [KW-1:0] st_data;
   logic [3:0]    st_round;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         st_valid = 1'b0;
         exp_done = 1'b0;
      end else begin
         if (bus.done || exp_done) chk("done_pulse", KW'(bus.done), KW'(exp_done));
         exp_done = 1'b0;
         if (bus.rk_valid) begin
            if (st_valid) begin
               chk("stall_data",  bus.rk_data,        st_data);
               chk("stall_round", KW'(bus.rk_round), KW'(st_round));
            end
            if (bus.rk_ready) begin
               st_valid = 1'b0;
               if (q.size() == 0) begin
                  chk("unexpected_xfer_round", KW'(bus.rk_round), KW'(5'h1f));
               end else begin
                  e = q.pop_front();
                  chk("xfer_round", KW'(bus.rk_round), KW'(e.rnd));
                  chk("xfer_data",  bus.rk_data,        e.data);
                  chk("xfer_last",  KW'(bus.rk_last),  KW'(e.rnd == 4'd0));
                  exp_done = (bus.rk_round == 4'd0);
               end
            end else begin
               st_valid = 1'b1;
               st_data  = bus.rk_data;
               st_round = bus.rk_round;
            end
         end else begin
            st_valid = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      bus.key_load = 1'b0;
      bus.in_keys  = '0;
      bus.start    = 1'b0;
      bus.rk_ready = 1'b0;
`ifdef AES128_KEY_ZEROIZE_EN
      zeroize      = 1'b0;
`endif
      #12;
      chk_idle_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // start in IDLE is ignored
      pulse_start();
      tick();
      chk("idle_start_valid",  KW'(bus.rk_valid), '0);
      chk("idle_start_loaded", KW'(bus.loaded),   '0);

      // full back-to-back pass
      load(KEYS_A);
      chk("load_loaded", KW'(bus.loaded),   KW'(1));
      chk("load_valid",  KW'(bus.rk_valid), '0);
      bus.rk_ready = 1'b1;
      push_pass(KEYS_A);
      pulse_start();
      chk("first_round", KW'(bus.rk_round), KW'(10));
      chk("first_data",  bus.rk_data,        KEYS_A[KW*10 +: KW]);
      wait_drain("b2b", 1'b0);

      // random back-pressure
      bus.rk_ready = 1'b0;
      push_pass(KEYS_A);
      pulse_start();
      wait_drain("stall", 1'b1);

      // key_load aborts a stream at the round-6 presentation
      bus.rk_ready = 1'b1;
      push_pass(KEYS_A);
      pulse_start();
      ticks(4);
      chk("abort_at_round", KW'(bus.rk_round), KW'(6));
      bus.rk_ready = 1'b0;
      load(KEYS_B);
      chk("abort_valid",  KW'(bus.rk_valid), '0);
      chk("abort_loaded", KW'(bus.loaded),   KW'(1));
      chk("abort_left",   KW'(q.size()),     KW'(7));
      q.delete();
      ticks(3);
      bus.rk_ready = 1'b1;
      push_pass(KEYS_B);
      pulse_start();
      chk("newkey_data", bus.rk_data, KEYS_B[KW*10 +: KW]);
      wait_drain("newkey", 1'b0);

      // start mid-SERVE is ignored
      push_pass(KEYS_B);
      pulse_start();
      ticks(3);
      pulse_start();
      wait_drain("midstart", 1'b0);
      chk("midstart_idle", KW'(bus.rk_valid), '0);

      // key_load and start together serve the new schedule next cycle
      bus.in_keys  = KEYS_A;
      bus.key_load = 1'b1;
      bus.start    = 1'b1;
      push_pass(KEYS_A);
      tick();
      bus.key_load = 1'b0;
      bus.start    = 1'b0;
      chk("ldst_round", KW'(bus.rk_round), KW'(10));
      chk("ldst_data",  bus.rk_data,        KEYS_A[KW*10 +: KW]);
      wait_drain("ldst", 1'b0);

      // asynchronous reset mid-stream
      push_pass(KEYS_A);
      pulse_start();
      ticks(2);
      #2 rst = 1'b1;
      #1;
      chk_idle_outputs("async_rst");
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      tick();
      pulse_start();
      tick();
      chk("rst_start_valid",  KW'(bus.rk_valid), '0);
      chk("rst_start_loaded", KW'(bus.loaded),   '0);
      load(KEYS_A);
      chk("reload_loaded", KW'(bus.loaded), KW'(1));

`ifdef AES128_KEY_ZEROIZE_EN
      // zeroize wins over a simultaneous key_load
      push_pass(KEYS_A);
      pulse_start();
      wait_drain("prezero", 1'b0);
      zeroize      = 1'b1;
      bus.in_keys  = KEYS_B;
      bus.key_load = 1'b1;
      tick();
      zeroize      = 1'b0;
      bus.key_load = 1'b0;
      chk("zero_loaded", KW'(bus.loaded),   '0);
      chk("zero_data",   bus.rk_data,        '0);
      chk("zero_valid",  KW'(bus.rk_valid), '0);
      pulse_start();
      tick();
      chk("zero_start_valid", KW'(bus.rk_valid), '0);
      chk("zero_start_loaded", KW'(bus.loaded),  '0);
`endif

      ticks(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
